// File: rtl/uart_rx_core_if.sv
// Byte-side and line-side signals of the UART receiver, bundled for port connection.
// slave: the receiver core; master: the line driver / byte consumer side.
interface uart_rx_core_if #(
  parameter int DATA_W = 8
);
  logic              Din;
  logic              Tick;
  logic [DATA_W-1:0] DataOut;
  logic              Valid;
  logic              FrameErr;
  logic              ParityErr;
  logic              Busy;

  modport master (
    output Din,
    output Tick,
    input  DataOut,
    input  Valid,
    input  FrameErr,
    input  ParityErr,
    input  Busy
  );

  modport slave (
    input  Din,
    input  Tick,
    output DataOut,
    output Valid,
    output FrameErr,
    output ParityErr,
    output Busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: start-glitch rejection, mid-bit sampling, LSB-first
// deserialisation, stop/framing check, break hold-off. Define UART_RX_PARITY_EN for even parity.
module uart_rx_core #(
  parameter int DATA_W      = 8,
  parameter int OVS         = 16,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  uart_rx_core_if.slave bus
);

  localparam int TCNT_W = $clog2(OVS);
  localparam int BCNT_W = $clog2(DATA_W + 1);

  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVS / 2 - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVS - 1);
  localparam logic [BCNT_W-1:0] BCNT_DLAST = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] BCNT_SLAST = BCNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [TCNT_W-1:0]        tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]        bcnt_q, bcnt_d;
  logic [DATA_W-1:0]        shreg_q, shreg_d;
  logic [DATA_W-1:0]        dout_q, dout_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     serr_q, serr_d;
`ifdef UART_RX_PARITY_EN
  logic                     perr_q, perr_d;
  logic                     pbit_q, pbit_d;
`endif
  logic                     sdin;
  logic                     tcnt_last;

  assign sdin      = sync_q[SYNC_STAGES-1];
  assign tcnt_last = (tcnt_q == TCNT_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      serr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbit_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.Din};
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      serr_q  <= serr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbit_q  <= pbit_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    serr_d  = serr_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    pbit_d  = pbit_q;
`endif
    if (bus.Tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!sdin) state_d = S_START;
        end
        // Half-bit check of the start bit rejects glitches shorter than OVS/2 ticks.
        S_START: begin
          if (tcnt_q == TCNT_MID) state_d = sdin ? S_IDLE : S_DATA;
          else                    tcnt_d  = tcnt_q + TCNT_W'(1);
        end
        S_DATA: begin
          if (tcnt_last) begin
            tcnt_d  = '0;
            shreg_d = {sdin, shreg_q[DATA_W-1:1]};
            if (bcnt_q == BCNT_DLAST) begin
              serr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tcnt_last) begin
            pbit_d  = sdin;
            state_d = S_STOP;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
`endif
        // Final stop sample publishes the word; a low stop bit parks us in BREAK.
        S_STOP: begin
          if (tcnt_last) begin
            tcnt_d = '0;
            if (bcnt_q == BCNT_SLAST) begin
              dout_d  = shreg_q;
              valid_d = 1'b1;
              ferr_d  = serr_q | ~sdin;
`ifdef UART_RX_PARITY_EN
              perr_d  = pbit_q ^ (^shreg_q);
`endif
              state_d = (serr_q | ~sdin) ? S_BREAK : S_IDLE;
            end else begin
              serr_d = serr_q | ~sdin;
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        S_BREAK: begin
          if (sdin) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) begin
        tcnt_d = '0;
        bcnt_d = '0;
      end
    end
  end

  assign bus.DataOut  = dout_q;
  assign bus.Valid    = valid_q;
  assign bus.FrameErr = ferr_q;
  assign bus.Busy     = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.ParityErr = perr_q;
`else
  assign bus.ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: vector table, hand-built corner sequences and random
// frames scored against a frame-level expectation queue.
module tb_uart_rx_core;
  localparam int DATA_W      = 8;
  localparam int OVS         = 16;
  localparam int STOP_BITS   = 1;
  localparam int SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pflip;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  localparam int NVEC = 7;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_gap = 0;
  rec_t act_q[$];
  rec_t exp_q[$];
  logic prev_vld = 1'b0;

  uart_rx_core_if #(.DATA_W(DATA_W)) bus ();

  uart_rx_core #(
    .DATA_W(DATA_W), .OVS(OVS), .STOP_BITS(STOP_BITS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every Valid is logged; a Valid lasting two cycles is an error.
  always @(negedge Clk) begin
    if (bus.Valid) begin
      act_q.push_back('{bus.DataOut, bus.FrameErr, bus.ParityErr});
      chk("valid_pulse_width", prev_vld, 0);
    end
    prev_vld <= bus.Valid;
  end

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < tick_gap; g++) begin
        bus.Tick = 1'b0;
        @(posedge Clk); #1;
      end
      bus.Tick = 1'b1;
      @(posedge Clk); #1;
      bus.Tick = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.Din = b;
    do_tick(OVS);
  endtask

  task automatic idle_bits(input int n);
    bus.Din = 1'b1;
    do_tick(n * OVS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ pflip);
    for (int i = 0; i < STOP_BITS; i++) send_bit(stop);
  endtask

  task automatic expect_one(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    rec_t r;
    chk({tag, "_count"}, act_q.size(), 1);
    if (act_q.size() > 0) begin
      r = act_q.pop_front();
      chk({tag, "_data"}, r.d, d);
      chk({tag, "_ferr"}, r.fe, fe);
      chk({tag, "_perr"}, r.pe, pe);
    end
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: cycle budget exceeded, got no finish required finish");
    $fatal(1);
  end

  initial begin
    vec_t vec[NVEC];
    logic [7:0] d;
    logic       stop, pflip;
    int         gap, glen, n;
    rec_t       r;

    vec[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 1'b0, 1'b0};
    vec[1] = '{8'h07, 1'b1, 1'b0, 1, 8'h07, 1'b0, 1'b0};
    vec[2] = '{8'h07, 1'b1, 1'b1, 1, 8'h07, 1'b0, 1'b1};
    vec[3] = '{8'h3C, 1'b0, 1'b0, 2, 8'h3C, 1'b1, 1'b0};
    vec[4] = '{8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    vec[5] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 1'b0, 1'b0};
    vec[6] = '{8'h81, 1'b1, 1'b1, 1, 8'h81, 1'b0, 1'b1};

    bus.Din  = 1'b1;
    bus.Tick = 1'b0;
    Rst      = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("rst_dataout", bus.DataOut, 0);
    chk("rst_valid", bus.Valid, 0);
    chk("rst_ferr", bus.FrameErr, 0);
    chk("rst_perr", bus.ParityErr, 0);
    chk("rst_busy", bus.Busy, 0);
    Rst = 1'b0;
    idle_bits(2);

    // 0xA5 by hand with Busy observed across the frame
    chk("a5_busy_idle", bus.Busy, 0);
    act_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d_a5(i));
    chk("a5_busy_mid", bus.Busy, 1);
    for (int i = 4; i < DATA_W; i++) send_bit(d_a5(i));
    if (PAR_EN) send_bit(^8'hA5);
    send_bit(1'b1);
    expect_one("a5", 8'hA5, 1'b0, 1'b0);
    idle_bits(1);
    chk("a5_busy_after", bus.Busy, 0);

    // Start glitch: low 5 ticks then high
    bus.Din = 1'b0;
    do_tick(5);
    bus.Din = 1'b1;
    chk("glitch_busy_hi", bus.Busy, 1);
    n = 0;
    while (bus.Busy && n < 2 * OVS) begin
      do_tick(1);
      n++;
    end
    chk("glitch_busy_lo", bus.Busy, 0);
    idle_bits(2);
    chk("glitch_no_valid", act_q.size(), 0);
    chk("dataout_hold", bus.DataOut, 8'hA5);

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      act_q.delete();
      send_frame(vec[i].data, vec[i].stop, vec[i].pflip);
      idle_bits(vec[i].gap);
      expect_one($sformatf("vec%0d", i), vec[i].exp_data, vec[i].exp_fe, vec[i].exp_pe & PAR_EN);
    end

    // Framing error followed by a long break
    act_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    bus.Din = 1'b0;
    do_tick(40 * OVS);
    expect_one("brk", 8'h3C, 1'b1, 1'b0);
    chk("brk_busy", bus.Busy, 1);
    idle_bits(2);
    chk("brk_no_extra", act_q.size(), 0);
    chk("brk_ferr_hold", bus.FrameErr, 1);

    // Reset in the middle of data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.Din = 1'b1;
    do_tick(OVS / 2);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("mrst_dataout", bus.DataOut, 0);
    chk("mrst_valid", bus.Valid, 0);
    chk("mrst_ferr", bus.FrameErr, 0);
    chk("mrst_perr", bus.ParityErr, 0);
    chk("mrst_busy", bus.Busy, 0);
    Rst = 1'b0;
    do_tick(OVS / 2 + 4 * OVS);
    idle_bits(1);
    chk("mrst_no_valid", act_q.size(), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(1);
    expect_one("mrst_next", 8'h81, 1'b0, 1'b0);

    // Random frames: frame-level expectations, random tick spacing, gaps and idle glitches
    act_q.delete();
    exp_q.delete();
    for (int k = 0; k < 30; k++) begin
      d        = 8'($urandom);
      stop     = ($urandom_range(0, 4) != 0);
      pflip    = 1'($urandom_range(0, 1));
      gap      = $urandom_range(stop ? 0 : 1, 2);
      tick_gap = $urandom_range(0, 2);
      exp_q.push_back('{d, ~stop, pflip & PAR_EN});
      send_frame(d, stop, pflip);
      if (gap > 0 && $urandom_range(0, 2) == 0) begin
        glen    = $urandom_range(1, 3);
        bus.Din = 1'b0;
        do_tick(glen);
        bus.Din = 1'b1;
        do_tick(OVS - glen);
        idle_bits(gap - 1);
      end else begin
        idle_bits(gap);
      end
    end
    idle_bits(2);
    chk("rand_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        r = act_q[i];
        chk($sformatf("rand%0d_data", i), r.d, exp_q[i].d);
        chk($sformatf("rand%0d_ferr", i), r.fe, exp_q[i].fe);
        chk($sformatf("rand%0d_perr", i), r.pe, exp_q[i].pe);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic d_a5(input int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction

endmodule
